// File: rtl/delay_timer_ext_if.sv
// Control/status bundle for the extended delay timer.
// The sequencer side (master) drives the request and configuration,
// and the timer side (slave) returns the expiry pulse and live status.
interface delay_timer_ext_if #(
   parameter int WIDTH = 14,
   parameter int PW    = 16
);
   logic             trigger;
   logic [WIDTH-1:0] N;
   logic [PW-1:0]    tick_div;
   logic             periodic;
   logic             pause;
   logic             abort;
   logic             time_out;
   logic             busy;
   logic [WIDTH-1:0] remaining;

   modport master (
      output trigger, N, tick_div, periodic, pause, abort,
      input  time_out, busy, remaining
   );

   modport slave (
      input  trigger, N, tick_div, periodic, pause, abort,
      output time_out, busy, remaining
   );
endinterface

// File: rtl/delay_timer_ext.sv
// Prescaled delay timer with one-shot / auto-reload modes, pause, abort and
// a selectable retrigger policy. One tick = tick_div+1 clk cycles; a start
// sampled at edge k expires at edge k + N*(tick_div+1).
module delay_timer_ext #(
   parameter int WIDTH     = 14,
   parameter int PW        = 16,
   parameter int RETRIGGER = 1
) (
   input  logic               clk,
   input  logic               rst,
   delay_timer_ext_if.slave   bus
);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      COUNTING = 2'd1,
      PAUSED   = 2'd2
   } state_e;

   localparam bit RETRIG_EN = (RETRIGGER != 0);

   state_e           state_q,    state_d;
   logic             trig_q,     trig_d;
   logic [PW-1:0]    pre_q,      pre_d;
   logic [WIDTH-1:0] rem_q,      rem_d;
   logic [WIDTH-1:0] n_q,        n_d;
   logic [PW-1:0]    div_q,      div_d;
   logic             per_q,      per_d;
   logic             time_out_q, time_out_d;

   logic             start;
   logic             accept;

   // Next-state computation; priority is abort > accepted start > pause > count.
   always_comb begin
      // NOTE: every variable gets a default first so no path leaves it
      // unassigned, which would otherwise infer a latch.
      state_d    = state_q;
      trig_d     = bus.trigger;
      pre_d      = pre_q;
      rem_d      = rem_q;
      n_d        = n_q;
      div_d      = div_q;
      per_d      = per_q;
      time_out_d = 1'b0;

      start  = bus.trigger & ~trig_q;
      accept = start & ((state_q == IDLE) | RETRIG_EN);

      if (bus.abort) begin
         state_d = IDLE;
         rem_d   = '0;
         pre_d   = '0;
      end else if (accept) begin
         n_d   = bus.N;
         div_d = bus.tick_div;
         per_d = bus.periodic;
         pre_d = '0;
         rem_d = bus.N;
         if (bus.N == '0) begin
            // Zero-length delay: pulse immediately and never reload.
            time_out_d = 1'b1;
            state_d    = IDLE;
         end else begin
            state_d = COUNTING;
         end
      end else if (state_q != IDLE && bus.pause) begin
         state_d = PAUSED;
      end else if (state_q != IDLE) begin
         // Leaving PAUSED counts on the same edge, so a pause costs exactly
         // the number of edges pause was sampled high.
         state_d = COUNTING;
         if (pre_q == div_q) begin
            pre_d = '0;
            if (rem_q == WIDTH'(1)) begin
               time_out_d = 1'b1;
               if (per_q) begin
                  rem_d = n_q;
               end else begin
                  rem_d   = '0;
                  state_d = IDLE;
               end
            end else begin
               rem_d = rem_q - WIDTH'(1);
            end
         end else begin
            pre_d = pre_q + PW'(1);
         end
      end
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge clk) begin
      // NOTE: registers use non-blocking assignments so every flop samples
      // the pre-edge values regardless of statement order.
      if (rst) begin
         state_q    <= IDLE;
         trig_q     <= 1'b1;
         pre_q      <= '0;
         rem_q      <= '0;
         n_q        <= '0;
         div_q      <= '0;
         per_q      <= 1'b0;
         time_out_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         trig_q     <= trig_d;
         pre_q      <= pre_d;
         rem_q      <= rem_d;
         n_q        <= n_d;
         div_q      <= div_d;
         per_q      <= per_d;
         time_out_q <= time_out_d;
      end
   end

   assign bus.time_out  = time_out_q;
   assign bus.busy      = (state_q != IDLE);
   assign bus.remaining = rem_q;

endmodule

// File: doc/delay_timer_ext.md
Name: delay_timer_ext

Overview:
- Parametrised successor of the single-shot delay counter used by the start-light sequencer.
- Adds a clock-enable prescaler, one-shot and periodic (auto-reload) modes, pause/resume, abort, configurable retrigger policy and a live remaining-count output.
- Sits between the sequencer FSM and the randomised light-out delay logic. A single instance covers both the fixed 1 s light steps and the random hold delay.

Parameters:
- WIDTH, 14, width of delay length N and of remaining count
- PW, 16, width of prescaler divide value
- RETRIGGER, 1, 1 = start edge while busy restarts the timer; 0 = start edge while busy is ignored

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous active-high reset
- trigger  input  1  start request; only its rising edge matters
- N  input  WIDTH  delay length in ticks; sampled on accepted start
- tick_div  input  PW  prescaler; one tick = tick_div+1 clk cycles; sampled on accepted start
- periodic  input  1  1 = auto-reload after expiry; sampled on accepted start
- pause  input  1  level; freezes counting while high
- abort  input  1  level; cancels timer, no pulse
- time_out  output  1  registered single-cycle expiry pulse
- busy  output  1  high when state is not IDLE
- remaining  output  WIDTH  ticks still to elapse (registered)

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high, named clk and rst.
- Reset values: state IDLE, time_out 0, busy 0, remaining 0, prescaler 0, trigger history register 1.
  - Because the history register resets to 1, a trigger held high through reset does not start the timer. trigger must go low first.
- Edge detect: start = trigger & ~trig_q. trig_q is the registered trigger.
- States: IDLE, COUNTING, PAUSED.
- Priority per cycle: rst > abort > accepted start > pause > count.
- Accepted start:
  - In IDLE, any start edge is accepted.
  - In COUNTING or PAUSED, a start edge is accepted only if RETRIGGER=1. It restarts the timer from N and emits no pulse for the old run.
  - On acceptance: capture N, tick_div and periodic; prescaler <= 0; remaining <= N; state <= COUNTING.
- N=0 on start: time_out pulses in the next cycle, state returns to IDLE regardless of periodic, remaining stays 0.
- COUNTING, pause low:
  - If prescaler == captured tick_div: prescaler <= 0 and remaining decrements. Otherwise prescaler increments.
- Expiry: remaining == 1 and prescaler == tick_div in COUNTING.
  - time_out <= 1 for exactly one cycle.
  - One-shot: state <= IDLE, remaining <= 0.
  - Periodic: remaining <= captured N, state stays COUNTING, with no dead cycle between periods.
- Latency: a start sampled at edge k gives time_out high in the cycle following edge k + N*(tick_div+1). Periodic pulses are spaced exactly N*(tick_div+1) cycles apart.
- Pause:
  - pause high in COUNTING or PAUSED: state <= PAUSED; prescaler, remaining and all captured values hold; no expiry is possible.
  - pause low in PAUSED: state <= COUNTING; counting resumes on the following edge with no lost or extra cycles.
  - pause high in IDLE has no effect.
- Abort: state <= IDLE, remaining <= 0, prescaler <= 0, time_out <= 0, including in the expiry cycle. trig_q still updates.
- A start edge coinciding with an expiry under RETRIGGER=1: the start wins, no pulse is emitted, and the timer reloads.
- busy = (state != IDLE), decoded from registered state. remaining is stable while PAUSED.
- Widths:
  - Decrement never wraps: remaining >= 1 in COUNTING, except for the N=0 path.
  - The prescaler compare is full-width unsigned.
  - Maximum delay is (2^WIDTH-1)*2^PW cycles.

Test Plan:
- One-shot, N=3, tick_div=0, trigger rises at edge 10 → time_out high only in the cycle after edge 13; busy high over edges 10-12; remaining reads 3,2,1,0.
- Periodic, N=2, tick_div=1 → time_out pulses every 4 cycles; abort asserted between pulses → no further pulse, busy=0, remaining=0.
- Pause: N=5, tick_div=0, pause high for 3 cycles with remaining=3 → remaining holds at 3; time_out occurs 3 cycles later than the unpaused run.
- Retrigger:
  - RETRIGGER=1: second edge at remaining=2 with N=4 → reload to 4, single pulse 4 cycles after the second edge.
  - RETRIGGER=0: same stimulus → pulse at the original time.
- N=0 start → one time_out pulse next cycle, state IDLE, even with periodic=1.
- Trigger held high through reset release → no start. Toggling trigger low then high → normal start. rst mid-count → all outputs return to reset values next cycle.
